// File: rtl/game_pkg.sv
// Shared constants for the brick-breaker game sequencer.
// State codes, default sizing and the brick x-origin table.
package game_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_FRAME = 3'd1;
  localparam logic [2:0] S_UPD_PADDLE = 3'd2;
  localparam logic [2:0] S_UPD_BALL   = 3'd3;
  localparam logic [2:0] S_UPD_BRICK  = 3'd4;
  localparam logic [2:0] S_CHECK      = 3'd5;
  localparam logic [2:0] S_LOSE       = 3'd6;
  localparam logic [2:0] S_WIN        = 3'd7;

  localparam int N_BRICKS_DEF    = 6;
  localparam int BRICK_DIV_DEF   = 60;
  localparam int ACK_TIMEOUT_DEF = 255;
  localparam int LIVES_DEF       = 3;

  // Left pixel column of each brick, shared with the game wrapper.
  localparam logic [9:0] BRICK_X0 [0:5] = '{
    10'd20, 10'd120, 10'd220,
    10'd320, 10'd420, 10'd520
  };

endpackage

// File: rtl/game_update_sequencer_hs_timer.sv
// hs_timer: wait counter for one req/ack handshake.
// Ports: clk, rst (sync, active-low), clr (restart), expired (limit hit).
module hs_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q is the number of edges seen since entry; the req has then
  // been high LIMIT cycles when the edge sampling LIMIT-1 arrives.
  assign expired = (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_update_sequencer.sv
// Frame-synchronous paddle/ball/brick update scheduler with win/lose.
// Ports: clk, rst (sync, active-low), frame_start, start (active-low),
//   paddle/ball/brick req+ack, bricks_exist, death_zone, ball_lost,
//   game_over, victory, frame_overrun, ack_timeout, lives_left.
// Build option: GAME_SEQ_LIVES_EN enables the lives counter.
module game_update_sequencer
  import game_pkg::*;
#(
  parameter int N_BRICKS    = N_BRICKS_DEF,
  parameter int BRICK_DIV   = BRICK_DIV_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int LIVES       = LIVES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                start,
  output logic                paddle_req,
  input  logic                paddle_ack,
  output logic                ball_req,
  input  logic                ball_ack,
  output logic                brick_req,
  input  logic                brick_ack,
  input  logic [N_BRICKS-1:0] bricks_exist,
  input  logic [N_BRICKS-1:0] death_zone,
  input  logic                ball_lost,
  output logic                game_over,
  output logic                victory,
  output logic                frame_overrun,
  output logic                ack_timeout,
  output logic [1:0]          lives_left
);

  localparam int DW = (BRICK_DIV > 1) ? $clog2(BRICK_DIV) : 1;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          brick_due_q, brick_due_d;
  logic          paddle_req_q, paddle_req_d;
  logic          ball_req_q, ball_req_d;
  logic          brick_req_q, brick_req_d;
  logic          game_over_q, game_over_d;
  logic          victory_q, victory_d;
  logic          overrun_q, overrun_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    lives_q, lives_d;
  logic          tmr_clr, tmr_exp;
  logic          busy;

  hs_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_hs_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .expired(tmr_exp)
  );

  // Every state change restarts the handshake deadline.
  assign tmr_clr = (state_d != state_q);

  assign busy = (state_q == S_UPD_PADDLE) ||
                (state_q == S_UPD_BALL) ||
                (state_q == S_UPD_BRICK) ||
                (state_q == S_CHECK);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    brick_due_d = brick_due_q;
    tmo_d       = tmo_q;
    lives_d     = lives_q;
    overrun_d   = overrun_q | (busy & frame_start);
    unique case (state_q)
      S_IDLE: begin
        if (!start) state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (frame_start) begin
          state_d = S_UPD_PADDLE;
          if (div_q == DW'(BRICK_DIV - 1)) begin
            div_d = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
          brick_due_d = (div_q == DW'(BRICK_DIV - 1));
        end
      end
      S_UPD_PADDLE: begin
        if (paddle_req_q && paddle_ack) begin
          state_d = S_UPD_BALL;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = S_UPD_BALL;
        end
      end
      S_UPD_BALL: begin
        if ((ball_req_q && ball_ack) || tmr_exp) begin
          if (!(ball_req_q && ball_ack)) tmo_d = 1'b1;
          state_d = brick_due_q ? S_UPD_BRICK : S_CHECK;
        end
      end
      S_UPD_BRICK: begin
        if (brick_req_q && brick_ack) begin
          state_d = S_CHECK;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Lose conditions are tested first so lose beats win.
        if (|death_zone) begin
          state_d = S_LOSE;
        end else if (ball_lost) begin
`ifdef GAME_SEQ_LIVES_EN
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = S_IDLE;
          end else begin
            lives_d = 2'd0;
            state_d = S_LOSE;
          end
`else
          state_d = S_LOSE;
`endif
        end else if (bricks_exist == '0) begin
          state_d = S_WIN;
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end
      S_LOSE:  state_d = S_LOSE;
      S_WIN:   state_d = S_WIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Requests are a registered decode of the next state, so exactly
  // one can be high and each drops on the edge that leaves its state.
  assign paddle_req_d = (state_d == S_UPD_PADDLE);
  assign ball_req_d   = (state_d == S_UPD_BALL);
  assign brick_req_d  = (state_d == S_UPD_BRICK);
  assign game_over_d  = game_over_q | (state_d == S_LOSE);
  assign victory_d    = victory_q | (state_d == S_WIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      brick_due_q  <= 1'b0;
      paddle_req_q <= 1'b0;
      ball_req_q   <= 1'b0;
      brick_req_q  <= 1'b0;
      game_over_q  <= 1'b0;
      victory_q    <= 1'b0;
      overrun_q    <= 1'b0;
      tmo_q        <= 1'b0;
`ifdef GAME_SEQ_LIVES_EN
      lives_q      <= 2'(LIVES);
`else
      lives_q      <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      brick_due_q  <= brick_due_d;
      paddle_req_q <= paddle_req_d;
      ball_req_q   <= ball_req_d;
      brick_req_q  <= brick_req_d;
      game_over_q  <= game_over_d;
      victory_q    <= victory_d;
      overrun_q    <= overrun_d;
      tmo_q        <= tmo_d;
      lives_q      <= lives_d;
    end
  end

`ifdef GAME_SEQ_LIVES_EN
  assign lives_left = lives_q;
`else
  logic [2:0] unused_lives;
  assign unused_lives = {2'(LIVES), ^lives_q};
  assign lives_left   = 2'd0;
`endif

  assign paddle_req    = paddle_req_q;
  assign ball_req      = ball_req_q;
  assign brick_req     = brick_req_q;
  assign game_over     = game_over_q;
  assign victory       = victory_q;
  assign frame_overrun = overrun_q;
  assign ack_timeout   = tmo_q;

endmodule

// File: tb/tb_game_update_sequencer.sv
// Directed bench for game_update_sequencer.
// Runs with or without GAME_SEQ_LIVES_EN.
module tb_game_update_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       start;
  logic [2:0] acks;
  logic [5:0] bricks_exist;
  logic [5:0] death_zone;
  logic       ball_lost;
  logic       paddle_req, ball_req, brick_req;
  logic       game_over, victory, frame_overrun, ack_timeout;
  logic [1:0] lives_left;
  logic [2:0] reqs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign reqs = {brick_req, ball_req, paddle_req};

  game_update_sequencer #(
    .N_BRICKS   (6),
    .BRICK_DIV  (2),
    .ACK_TIMEOUT(8),
    .LIVES      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .start        (start),
    .paddle_req   (paddle_req),
    .paddle_ack   (acks[0]),
    .ball_req     (ball_req),
    .ball_ack     (acks[1]),
    .brick_req    (brick_req),
    .brick_ack    (acks[2]),
    .bricks_exist (bricks_exist),
    .death_zone   (death_zone),
    .ball_lost    (ball_lost),
    .game_over    (game_over),
    .victory      (victory),
    .frame_overrun(frame_overrun),
    .ack_timeout  (ack_timeout),
    .lives_left   (lives_left)
  );

  localparam logic [31:0] ST_IDLE  = 0;
  localparam logic [31:0] ST_WAIT  = 1;
  localparam logic [31:0] ST_CHECK = 5;
  localparam logic [31:0] ST_WIN   = 7;

`ifdef GAME_SEQ_LIVES_EN
  localparam logic [31:0] LIVES_RST = 3;
`else
  localparam logic [31:0] LIVES_RST = 0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot_req", 32'($onehot0(reqs)), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b1;
    frame_start = 1'b0;
    acks = 3'b000;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic serve(input int which, input int dly);
    int n = 0;
    while (!reqs[which] && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(reqs[which]), 1);
    repeat (dly) tick();
    chk("req_held", 32'(reqs[which]), 1);
    acks[which] = 1'b1;
    tick();
    acks[which] = 1'b0;
    chk("req_drop", 32'(reqs[which]), 0);
  endtask

  task automatic go_wait();
    start = 1'b0;
    tick();
    start = 1'b1;
    chk("to_wait", 32'(dut.state_q), ST_WAIT);
  endtask

  task automatic run_frame(input bit brick, input int dly);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    serve(0, dly);
    serve(1, dly);
    if (brick) begin
      serve(2, dly);
    end else begin
      chk("no_brick", 32'(brick_req), 0);
    end
    chk("at_check", 32'(dut.state_q), ST_CHECK);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    frame_start = 1'b0;
    acks = 3'b000;
    bricks_exist = 6'h3f;
    death_zone = 6'h00;
    ball_lost = 1'b0;

    // 1: reset state, IDLE ignores frame_start, first request
    tick();
    tick();
    chk("rst_reqs", 32'(reqs), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_vict", 32'(victory), 0);
    chk("rst_ovr", 32'(frame_overrun), 0);
    chk("rst_tmo", 32'(ack_timeout), 0);
    chk("rst_lives", 32'(lives_left), LIVES_RST);
    chk("rst_state", 32'(dut.state_q), ST_IDLE);
    rst = 1'b1;
    start = 1'b1;
    frame_start = 1'b1;
    tick();
    chk("idle_fs", 32'(paddle_req), 0);
    chk("idle_st", 32'(dut.state_q), ST_IDLE);
    frame_start = 1'b0;
    go_wait();
    acks = 3'b111;
    tick();
    acks = 3'b000;
    chk("stray_ack", 32'(dut.state_q), ST_WAIT);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("paddle_req1", 32'(paddle_req), 1);

    // 2: 3-cycle acks, brick step on every second frame
    serve(0, 3);
    serve(1, 3);
    chk("f1_nobrick", 32'(brick_req), 0);
    chk("f1_check", 32'(dut.state_q), ST_CHECK);
    tick();
    chk("f1_wait", 32'(dut.state_q), ST_WAIT);
    run_frame(1'b1, 3);
    tick();
    run_frame(1'b0, 3);
    tick();
    chk("no_ovr", 32'(frame_overrun), 0);
    chk("no_tmo", 32'(ack_timeout), 0);

    // 5: frame_start during UPD_BALL is dropped
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    serve(0, 0);
    chk("in_ball", 32'(ball_req), 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_set", 32'(frame_overrun), 1);
    serve(1, 1);
    serve(2, 0);
    chk("f4_check", 32'(dut.state_q), ST_CHECK);
    tick();
    repeat (3) tick();
    chk("ovr_noseq", 32'(reqs), 0);
    chk("ovr_wait", 32'(dut.state_q), ST_WAIT);

    // 4: ball ack withheld, deadline of 8 cycles
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    serve(0, 0);
    begin
      int n = 0;
      while (ball_req && n < 50) begin
        tick();
        n++;
      end
      chk("tmo_len", 32'(n), 8);
    end
    chk("tmo_flag", 32'(ack_timeout), 1);
    chk("tmo_cont", 32'(dut.state_q), ST_CHECK);
    tick();
    chk("tmo_wait", 32'(dut.state_q), ST_WAIT);

    // 6: ball_lost handling
    ball_lost = 1'b1;
    run_frame(1'b1, 0);
    tick();
`ifdef GAME_SEQ_LIVES_EN
    chk("lives_2", 32'(lives_left), 2);
    chk("reserve1", 32'(dut.state_q), ST_IDLE);
    chk("not_over1", 32'(game_over), 0);
    go_wait();
    run_frame(1'b0, 0);
    tick();
    chk("lives_1", 32'(lives_left), 1);
    chk("reserve2", 32'(dut.state_q), ST_IDLE);
    go_wait();
    run_frame(1'b1, 0);
    tick();
    chk("lives_0", 32'(lives_left), 0);
`endif
    chk("lost_over", 32'(game_over), 1);
    chk("lost_vict", 32'(victory), 0);
    ball_lost = 1'b0;

    do_reset();
    chk("rst2_over", 32'(game_over), 0);
    chk("rst2_ovr", 32'(frame_overrun), 0);
    chk("rst2_tmo", 32'(ack_timeout), 0);
    chk("rst2_lives", 32'(lives_left), LIVES_RST);

    // win: all bricks cleared
    bricks_exist = 6'h00;
    go_wait();
    run_frame(1'b0, 1);
    tick();
    chk("win_vict", 32'(victory), 1);
    chk("win_over", 32'(game_over), 0);
    repeat (3) tick();
    chk("win_hold", 32'(dut.state_q), ST_WIN);

    // 3: lose beats win, terminal across 100 frames
    do_reset();
    chk("rst3_vict", 32'(victory), 0);
    death_zone = 6'b001000;
    go_wait();
    run_frame(1'b0, 2);
    tick();
    chk("dz_over", 32'(game_over), 1);
    chk("dz_vict", 32'(victory), 0);
    repeat (100) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    chk("dz_hold", 32'(game_over), 1);
    chk("dz_hvict", 32'(victory), 0);
    chk("dz_reqs", 32'(reqs), 0);
    chk("dz_ovr", 32'(frame_overrun), 0);

    // 6: reset during UPD_PADDLE drops req, late ack ignored
    do_reset();
    death_zone = 6'h00;
    bricks_exist = 6'h3f;
    go_wait();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("mid_req", 32'(paddle_req), 1);
    rst = 1'b0;
    tick();
    chk("mid_drop", 32'(paddle_req), 0);
    chk("mid_idle", 32'(dut.state_q), ST_IDLE);
    rst = 1'b1;
    acks[0] = 1'b1;
    tick();
    acks[0] = 1'b0;
    chk("late_idle", 32'(dut.state_q), ST_IDLE);
    chk("late_reqs", 32'(reqs), 0);
    chk("late_tmo", 32'(ack_timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
